// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
//
// One request is granted at a time. Its operands are registered, the ALU
// gets one cycle to settle (ISSUE), and its outputs are captured and
// returned on the granted requester's response channel (RESP). A full
// operation takes at least 3 cycles: accept, issue, respond.
//
// Arbitration: a lone valid requester always wins. When both are valid,
// a round-robin pointer picks the winner. The pointer moves only when a
// response completes, so neither side can starve.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  requester 0 always wins simultaneous requests
//                          and the pointer is removed.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   reqX_valid/ready         request handshake; ready is combinational
//   reqX_a/b/op              operands and ALUctr code
//   respX_valid/ready        response handshake, one per requester
//   resp_result/zero/
//   resp_overflow/resp_err   captured ALU outputs, shared by both channels
//   alu_a/b/ctr              registered drive to the shared ALU
//   alu_result/zero/overflow combinational ALU outputs
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [N-1:0] resp_result,
  output logic         resp_zero,
  output logic         resp_overflow,
  output logic         resp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_ctr,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_overflow
);

  localparam logic [2:0] OP_ILLEGAL = 3'b011;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
  } req_t;

  state_t     state;
  req_t       req_q;
  req_t [1:0] req_in;
  logic [1:0] vld;
  logic [1:0] rdy;
  logic [1:0] resp_vld_q;
  logic       win;
  logic       gnt_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic       ptr;
`endif

  assign vld       = {req1_valid, req0_valid};
  assign req_in[0] = {req0_a, req0_b, req0_op};
  assign req_in[1] = {req1_a, req1_b, req1_op};

  // Winner select; only meaningful when at least one request is valid.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    win = ~vld[0];
`else
    win = (&vld) ? ptr : vld[1];
`endif
  end

  // Ready only in IDLE and only to the winner; held low during reset.
  assign rdy        = (state == IDLE && !rst) ? (vld & (win ? 2'b10 : 2'b01)) : 2'b00;
  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  // ALU drive comes straight from the latched request, so it holds the
  // last operands between operations instead of returning to zero.
  assign alu_a   = req_q.a;
  assign alu_b   = req_q.b;
  assign alu_ctr = req_q.op;

  assign resp0_valid = resp_vld_q[0];
  assign resp1_valid = resp_vld_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      req_q         <= '0;
      gnt_q         <= 1'b0;
      resp_vld_q    <= 2'b00;
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_err      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|rdy) begin
            req_q <= req_in[win];
            gnt_q <= win;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (req_q.op == OP_ILLEGAL) begin
            // ALU output is meaningless for this code; report a clean error.
            resp_result   <= '0;
            resp_zero     <= 1'b1;
            resp_overflow <= 1'b0;
            resp_err      <= 1'b1;
          end else begin
            resp_result   <= alu_result;
            resp_zero     <= alu_zero;
            resp_overflow <= alu_overflow;
            resp_err      <= 1'b0;
          end
          resp_vld_q <= {gnt_q, ~gnt_q};
          state      <= RESP;
        end
        RESP: begin
          if (|(resp_vld_q & {resp1_ready, resp0_ready})) begin
            resp_vld_q <= 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr        <= ~gnt_q;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
